// File: rtl/prefetch_cache_pkg.sv
// Shared encodings for the prefetch cache control FSM.
package prefetch_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FETCH,
        PF_FILL
    } state_t;

    localparam logic [1:0] DIN_PMEM = 2'b00;
    localparam logic [1:0] DIN_CPU  = 2'b01;
    localparam logic [1:0] DIN_PF   = 2'b11;

    localparam logic [1:0] WE_NONE  = 2'b00;
    localparam logic [1:0] WE_ALL   = 2'b01;
    localparam logic [1:0] WE_BYTE  = 2'b10;

    localparam logic PADDR_VICTIM = 1'b0;
    localparam logic PADDR_CPU    = 1'b1;

endpackage

// File: rtl/prefetch_cache_control_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/prefetch_cache_control.sv
// Control FSM for the 2-way prefetch cache: hit service, writeback,
// pmem fill and prefetch-buffer fill.
module prefetch_cache_control
    import prefetch_cache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             miss,
    input  logic             way,
    input  logic             dirty_out,
    input  logic             pf_hit,
    output logic             pf_trigger,
    output logic             pf_consume,
    output logic [1:0]       data_in_sel,
    output logic             pmem_addr_sel,
    output logic [1:0]       wr_en_data_0_sel,
    output logic [1:0]       wr_en_data_1_sel,
    output logic             dirty_in,
    output logic             valid_in,
    output logic             ld_dirty_0,
    output logic             ld_dirty_1,
    output logic             ld_valid_0,
    output logic             ld_valid_1,
    output logic             ld_tag_0,
    output logic             ld_tag_1,
    output logic             ld_lru,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] pf_fill_count
);

    state_t r_state;
    state_t w_next;
    logic   r_retry;
    logic   w_retry_next;
    logic   w_inc_miss;
    logic   w_inc_pf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_retry <= 1'b0;
        end else begin
            r_state <= w_next;
            r_retry <= w_retry_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_retry_next     = r_retry;
        w_inc_miss       = 1'b0;
        w_inc_pf         = 1'b0;
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pf_trigger       = 1'b0;
        pf_consume       = 1'b0;
        data_in_sel      = DIN_PMEM;
        pmem_addr_sel    = PADDR_VICTIM;
        wr_en_data_0_sel = WE_NONE;
        wr_en_data_1_sel = WE_NONE;
        dirty_in         = 1'b0;
        valid_in         = 1'b0;
        ld_dirty_0       = 1'b0;
        ld_dirty_1       = 1'b0;
        ld_valid_0       = 1'b0;
        ld_valid_1       = 1'b0;
        ld_tag_0         = 1'b0;
        ld_tag_1         = 1'b0;
        ld_lru           = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_next       = CHECK;
                    w_retry_next = 1'b0;
                end
            end
            CHECK: begin
                if (!miss) begin
                    ld_lru   = 1'b1;
                    mem_resp = 1'b1;
                    w_next   = IDLE;
                    // A simultaneous read and write is serviced as a write.
                    if (mem_write) begin
                        data_in_sel = DIN_CPU;
                        dirty_in    = 1'b1;
                        if (way) begin
                            wr_en_data_1_sel = WE_BYTE;
                            ld_dirty_1       = 1'b1;
                        end else begin
                            wr_en_data_0_sel = WE_BYTE;
                            ld_dirty_0       = 1'b1;
                        end
                    end
                end else begin
                    if (!r_retry) begin
                        pf_trigger = 1'b1;
                        w_inc_miss = 1'b1;
                    end
                    if (dirty_out) begin
                        w_next = WRITEBACK;
                    end else if (pf_hit) begin
                        w_next = PF_FILL;
                    end else begin
                        w_next = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = PADDR_VICTIM;
                if (pmem_resp) begin
                    dirty_in   = 1'b0;
                    ld_dirty_0 = !way;
                    ld_dirty_1 = way;
                    w_next     = pf_hit ? PF_FILL : FETCH;
                end
            end
            FETCH: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = PADDR_CPU;
                if (pmem_resp) begin
                    data_in_sel      = DIN_PMEM;
                    valid_in         = 1'b1;
                    dirty_in         = 1'b0;
                    wr_en_data_0_sel = way ? WE_NONE : WE_ALL;
                    wr_en_data_1_sel = way ? WE_ALL : WE_NONE;
                    ld_tag_0         = !way;
                    ld_tag_1         = way;
                    ld_valid_0       = !way;
                    ld_valid_1       = way;
                    ld_dirty_0       = !way;
                    ld_dirty_1       = way;
                    w_next           = CHECK;
                    w_retry_next     = 1'b1;
                end
            end
            PF_FILL: begin
                data_in_sel      = DIN_PF;
                valid_in         = 1'b1;
                dirty_in         = 1'b0;
                wr_en_data_0_sel = way ? WE_NONE : WE_ALL;
                wr_en_data_1_sel = way ? WE_ALL : WE_NONE;
                ld_tag_0         = !way;
                ld_tag_1         = way;
                ld_valid_0       = !way;
                ld_valid_1       = way;
                ld_dirty_0       = !way;
                ld_dirty_1       = way;
                pf_consume       = 1'b1;
                w_inc_pf         = 1'b1;
                w_next           = CHECK;
                w_retry_next     = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_miss),
        .count (miss_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_pf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_pf),
        .count (pf_fill_count)
    );

endmodule

// File: tb/tb_prefetch_cache_control.sv
// Directed bench for prefetch_cache_control; a CNT_W=2 copy shares the
// stimulus to show counter saturation.
module tb_prefetch_cache_control;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_write, pmem_resp;
    logic miss, way, dirty_out, pf_hit;

    logic        mem_resp, pmem_read, pmem_write, pf_trigger, pf_consume;
    logic [1:0]  data_in_sel, we0, we1;
    logic        pmem_addr_sel, dirty_in, valid_in;
    logic        ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1;
    logic        ld_tag_0, ld_tag_1, ld_lru;
    logic [31:0] miss_count, pf_fill_count;

    logic        s_mem_resp, s_pmem_read, s_pmem_write, s_pf_trigger, s_pf_consume;
    logic [1:0]  s_data_in_sel, s_we0, s_we1;
    logic        s_pmem_addr_sel, s_dirty_in, s_valid_in;
    logic        s_ld_dirty_0, s_ld_dirty_1, s_ld_valid_0, s_ld_valid_1;
    logic        s_ld_tag_0, s_ld_tag_1, s_ld_lru;
    logic [1:0]  s_miss_count, s_pf_fill_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prefetch_cache_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .miss(miss), .way(way), .dirty_out(dirty_out), .pf_hit(pf_hit),
        .pf_trigger(pf_trigger), .pf_consume(pf_consume),
        .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel),
        .wr_en_data_0_sel(we0), .wr_en_data_1_sel(we1),
        .dirty_in(dirty_in), .valid_in(valid_in),
        .ld_dirty_0(ld_dirty_0), .ld_dirty_1(ld_dirty_1),
        .ld_valid_0(ld_valid_0), .ld_valid_1(ld_valid_1),
        .ld_tag_0(ld_tag_0), .ld_tag_1(ld_tag_1), .ld_lru(ld_lru),
        .miss_count(miss_count), .pf_fill_count(pf_fill_count)
    );

    prefetch_cache_control #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(s_mem_resp),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_resp(pmem_resp),
        .miss(miss), .way(way), .dirty_out(dirty_out), .pf_hit(pf_hit),
        .pf_trigger(s_pf_trigger), .pf_consume(s_pf_consume),
        .data_in_sel(s_data_in_sel), .pmem_addr_sel(s_pmem_addr_sel),
        .wr_en_data_0_sel(s_we0), .wr_en_data_1_sel(s_we1),
        .dirty_in(s_dirty_in), .valid_in(s_valid_in),
        .ld_dirty_0(s_ld_dirty_0), .ld_dirty_1(s_ld_dirty_1),
        .ld_valid_0(s_ld_valid_0), .ld_valid_1(s_ld_valid_1),
        .ld_tag_0(s_ld_tag_0), .ld_tag_1(s_ld_tag_1), .ld_lru(s_ld_lru),
        .miss_count(s_miss_count), .pf_fill_count(s_pf_fill_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        miss      = 1'b0;
        way       = 1'b0;
        dirty_out = 1'b0;
        pf_hit    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
        chk("rst_miss_cnt", miss_count, 32'd0);
        chk("rst_pf_cnt", pf_fill_count, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // read hit, way 1
        mem_read = 1'b1; way = 1'b1; settle();
        chk("rh_c0_resp", {31'b0, mem_resp}, 32'd0);
        tick(); settle();
        chk("rh_resp", {31'b0, mem_resp}, 32'd1);
        chk("rh_lru", {31'b0, ld_lru}, 32'd1);
        chk("rh_we", {28'b0, we0, we1}, 32'd0);
        chk("rh_trig", {31'b0, pf_trigger}, 32'd0);
        tick(); mem_read = 1'b0; settle();
        chk("rh_idle_resp", {31'b0, mem_resp}, 32'd0);

        // write hit, way 0
        tick();
        mem_write = 1'b1; way = 1'b0; settle();
        tick(); settle();
        chk("wh_we0", {30'b0, we0}, 32'd2);
        chk("wh_we1", {30'b0, we1}, 32'd0);
        chk("wh_din", {30'b0, data_in_sel}, 32'd1);
        chk("wh_lddirty0", {30'b0, ld_dirty_0, ld_dirty_1}, 32'd2);
        chk("wh_dirty_in", {31'b0, dirty_in}, 32'd1);
        chk("wh_resp", {31'b0, mem_resp}, 32'd1);
        tick(); mem_write = 1'b0; settle();
        chk("wh_miss_cnt", miss_count, 32'd0);

        // dirty miss, way 1, no prefetch
        tick();
        mem_read = 1'b1; miss = 1'b1; dirty_out = 1'b1; way = 1'b1; settle();
        tick(); settle();
        chk("dm_trig", {31'b0, pf_trigger}, 32'd1);
        chk("dm_chk_pwr", {31'b0, pmem_write}, 32'd0);
        tick(); settle();
        chk("dm_pwr", {31'b0, pmem_write}, 32'd1);
        chk("dm_paddr_v", {31'b0, pmem_addr_sel}, 32'd0);
        chk("dm_trig_once", {31'b0, pf_trigger}, 32'd0);
        chk("dm_cnt_1", miss_count, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        pmem_resp = 1'b1; settle();
        chk("dm_wb_pwr", {31'b0, pmem_write}, 32'd1);
        chk("dm_wb_ld", {30'b0, ld_dirty_0, ld_dirty_1}, 32'd1);
        chk("dm_wb_din", {31'b0, dirty_in}, 32'd0);
        tick(); pmem_resp = 1'b0; dirty_out = 1'b0; settle();
        chk("dm_prd", {30'b0, pmem_read, pmem_write}, 32'd2);
        chk("dm_paddr_c", {31'b0, pmem_addr_sel}, 32'd1);
        chk("dm_ign_fill", {30'b0, ld_tag_0, ld_tag_1}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        pmem_resp = 1'b1; settle();
        chk("dm_tag", {30'b0, ld_tag_0, ld_tag_1}, 32'd1);
        chk("dm_valid", {30'b0, ld_valid_0, ld_valid_1}, 32'd1);
        chk("dm_valid_in", {31'b0, valid_in}, 32'd1);
        chk("dm_we", {28'b0, we0, we1}, 32'd1);
        chk("dm_din", {30'b0, data_in_sel}, 32'd0);
        chk("dm_fill_resp", {31'b0, mem_resp}, 32'd0);
        tick(); pmem_resp = 1'b0; miss = 1'b0; settle();
        chk("dm_resp", {31'b0, mem_resp}, 32'd1);
        chk("dm_no_trig", {31'b0, pf_trigger}, 32'd0);
        tick(); mem_read = 1'b0; settle();
        chk("dm_cnt", miss_count, 32'd1);

        // prefetch fill, way 0
        tick();
        mem_read = 1'b1; miss = 1'b1; pf_hit = 1'b1; way = 1'b0; settle();
        tick(); settle();
        chk("pf_trig", {31'b0, pf_trigger}, 32'd1);
        tick(); pf_hit = 1'b0; settle();
        chk("pf_din", {30'b0, data_in_sel}, 32'd3);
        chk("pf_consume", {31'b0, pf_consume}, 32'd1);
        chk("pf_we", {28'b0, we0, we1}, 32'd4);
        chk("pf_nopmem", {30'b0, pmem_read, pmem_write}, 32'd0);
        tick(); miss = 1'b0; settle();
        chk("pf_resp", {31'b0, mem_resp}, 32'd1);
        chk("pf_cons_once", {31'b0, pf_consume}, 32'd0);
        tick(); mem_read = 1'b0; settle();
        chk("pf_cnt", pf_fill_count, 32'd1);
        chk("pf_miss_cnt", miss_count, 32'd2);

        // reset during FETCH
        tick();
        mem_read = 1'b1; miss = 1'b1; way = 1'b1; settle();
        tick(); tick(); settle();
        chk("rf_prd", {31'b0, pmem_read}, 32'd1);
        rst = 1'b1; settle();
        chk("rf_prd_drop", {31'b0, pmem_read}, 32'd0);
        chk("rf_cnt", miss_count, 32'd0);
        chk("rf_pfcnt", pf_fill_count, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        mem_read = 1'b1; settle();
        chk("rf_idle", {31'b0, mem_resp}, 32'd0);
        tick(); settle();
        chk("rf_hit_resp", {31'b0, mem_resp}, 32'd1);
        tick(); mem_read = 1'b0; settle();

        // read and write together behaves as write, way 1
        tick();
        mem_read = 1'b1; mem_write = 1'b1; way = 1'b1; settle();
        tick(); settle();
        chk("rw_we1", {30'b0, we1}, 32'd2);
        chk("rw_ld", {30'b0, ld_dirty_0, ld_dirty_1}, 32'd1);
        tick(); mem_read = 1'b0; mem_write = 1'b0; settle();

        // five prefetch-served misses saturate the 2-bit counters
        for (int n = 0; n < 5; n++) begin
            tick();
            mem_read = 1'b1; miss = 1'b1; pf_hit = 1'b1; way = 1'b0; settle();
            tick(); tick();
            miss = 1'b0; pf_hit = 1'b0;
            tick(); settle();
            tick(); mem_read = 1'b0; settle();
        end
        chk("sat_miss_small", {30'b0, s_miss_count}, 32'd3);
        chk("sat_pf_small", {30'b0, s_pf_fill_count}, 32'd3);
        chk("sat_miss_big", miss_count, 32'd5);
        chk("sat_pf_big", pf_fill_count, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
